adc_sample_acquirer: RTL
========================

ADC_SAMPLE_ACQUIRER -- requirements
Module: adc_sample_acquirer

Interface
REQ-001 Parameter: CLK_DIV, 4, clk cycles per SCLK half-period (>=2).
REQ-002 Parameter: AVG_LOG2, 2, log2 of frames averaged per result (0..4).
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: start  input  1  acquisition request, sampled each clk.
REQ-006 Port: adc_miso  input  1  serial data from ADC, MSB first.
REQ-007 Port: adc_sclk  output  1  serial clock to ADC, idle low.
REQ-008 Port: adc_cs_n  output  1  ADC chip select, active low.
REQ-009 Port: adc_data  output  16  averaged sample; feeds TemperatureCalculator adc_data.
REQ-010 Port: data_valid  output  1  one-cycle pulse when adc_data updates.
REQ-011 Port: busy  output  1  high from accepted start until data_valid cycle inclusive.

Function
REQ-012 FSM states SHALL be IDLE, CS_SETUP, SHIFT, GAP, DONE.
REQ-013 IDLE: start=1 -> CS_SETUP, clear accumulator and frame counter; start=0 -> stay.
REQ-014 start while busy=1 SHALL be ignored (no queuing, no restart).
REQ-015 CS_SETUP: adc_cs_n=0, adc_sclk=0, lasts CLK_DIV cycles -> SHIFT.
REQ-016 SHIFT: adc_sclk toggles every CLK_DIV cycles, 16 full periods (32*CLK_DIV cycles), first edge rising.
REQ-017 adc_miso SHALL be captured into a 16-bit shift register on the clk cycle of each adc_sclk rising edge, MSB first.
REQ-018 After 16th capture: sample added to accumulator of width 16+AVG_LOG2 (no overflow possible) -> GAP.
REQ-019 GAP: adc_cs_n=1, adc_sclk=0, lasts CLK_DIV cycles; frame counter < 2^AVG_LOG2-1 -> increment, CS_SETUP; else -> DONE.
REQ-020 Frame length SHALL be exactly 34*CLK_DIV cycles.
REQ-021 DONE (one cycle): adc_data <= accumulator >> AVG_LOG2 (truncate), data_valid=1, then IDLE.
REQ-022 Latency: start sampled at edge 0 -> data_valid high in cycle 2^AVG_LOG2*34*CLK_DIV+1 (545 at defaults).
REQ-023 adc_data SHALL hold its value between data_valid pulses.
REQ-024 busy SHALL be 0 in IDLE, 1 in all other states.
REQ-025 AVG_LOG2=0: single frame, adc_data equals the raw sample.

Reset
REQ-026 rst=1 SHALL immediately force: state IDLE, adc_cs_n=1, adc_sclk=0, data_valid=0, busy=0, adc_data=16'h0000, accumulator/counters/shift register 0.
REQ-027 Reset mid-frame SHALL abort the frame; no partial result or data_valid is produced.
REQ-028 First start after rst deassertion SHALL be accepted on the first clk edge with rst=0.

Structure
REQ-029 Package adc_acq_pkg SHALL hold the FSM state type and constant FRAME_BITS=16.
REQ-030 Sub-module adc_sclk_gen SHALL generate the half-period tick and rising-edge strobe from CLK_DIV, enabled only in SHIFT.
REQ-031 Accumulator, counters and FSM SHALL stay in adc_sample_acquirer.

Verification
REQ-032 ADC model returns 0x1234 every frame, defaults -> data_valid at cycle 545, adc_data=0x1234.
REQ-033 Frames 0x0001,0x0002,0x0003,0x0004 -> adc_data=0x0002 (sum 10 >> 2).
REQ-034 Four frames of 0xFFFF -> adc_data=0xFFFF, no wrap.
REQ-035 start pulsed again at cycle 100 and 300 of an acquisition -> ignored, single data_valid at 545.
REQ-036 rst asserted mid-SHIFT of frame 2 -> same cycle adc_cs_n=1, adc_sclk=0, busy=0, adc_data=0x0000, no data_valid.
REQ-037 AVG_LOG2=0, CLK_DIV=2, sample 0xA5C3 -> data_valid at cycle 69, adc_data=0xA5C3; adc_sclk half-period exactly 2 cycles.

Source files
------------

// File: rtl/adc_acq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_acq_pkg
//  Purpose  : Shared state encoding and frame constants for the ADC acquirer
//  Revision : 1.0  initial release
// ============================================================================
package adc_acq_pkg;

    localparam int FRAME_BITS = 16;

    typedef logic [2:0] acq_state_t;

    localparam acq_state_t c_ST_IDLE     = 3'd0;
    localparam acq_state_t c_ST_CS_SETUP = 3'd1;
    localparam acq_state_t c_ST_SHIFT    = 3'd2;
    localparam acq_state_t c_ST_GAP      = 3'd3;
    localparam acq_state_t c_ST_DONE     = 3'd4;

endpackage : adc_acq_pkg
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sclk_gen
//  Purpose  : Half-period tick, rising-edge strobe and SCLK phase for the ADC
//  Revision : 1.0  initial release
// ============================================================================
module adc_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick,
    output logic o_rise,
    output logic o_sclk
);

    localparam int                 c_CNT_W   = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_phase;

    assign o_tick = i_en && (r_cnt == c_CNT_MAX);
    // A tick while the phase is low is the edge that drives SCLK high.
    assign o_rise = o_tick && !r_phase;
    assign o_sclk = r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (o_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule : adc_sclk_gen
`default_nettype wire

// File: rtl/adc_sample_acquirer.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sample_acquirer
//  Purpose  : Reads 2^AVG_LOG2 serial ADC frames and outputs their average
//  Revision : 1.0  initial release
// ============================================================================
module adc_sample_acquirer
    import adc_acq_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  adc_miso,
    output logic                  adc_sclk,
    output logic                  adc_cs_n,
    output logic [FRAME_BITS-1:0] adc_data,
    output logic                  data_valid,
    output logic                  busy
);

    localparam int                 c_ACC_W      = FRAME_BITS + AVG_LOG2;
    localparam int                 c_CNT_W      = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = c_CNT_W'(CLK_DIV - 1);
    localparam int                 c_FRM_W      = AVG_LOG2 + 1;
    localparam logic [c_FRM_W-1:0] c_LAST_FRAME = c_FRM_W'((1 << AVG_LOG2) - 1);
    localparam int                 c_HALF_W     = $clog2(2 * FRAME_BITS);
    localparam logic [c_HALF_W-1:0] c_LAST_HALF = c_HALF_W'(2 * FRAME_BITS - 1);

    acq_state_t            r_state;
    acq_state_t            w_next_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_HALF_W-1:0]   r_half;
    logic [c_FRM_W-1:0]    r_frame;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_adc_data;
    logic [c_ACC_W-1:0]    r_acc;

    logic w_shift_en;
    logic w_tick;
    logic w_rise;
    logic w_gen_sclk;
    logic w_phase_done;
    logic w_shift_done;
    logic w_more_frames;

    assign w_shift_en    = (r_state == c_ST_SHIFT);
    assign w_phase_done  = (r_cnt == c_CNT_MAX);
    assign w_shift_done  = w_tick && (r_half == c_LAST_HALF);
    assign w_more_frames = (r_frame < c_LAST_FRAME);
    assign adc_data      = r_adc_data;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_shift_en),
        .o_tick (w_tick),
        .o_rise (w_rise),
        .o_sclk (w_gen_sclk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        adc_cs_n     = 1'b1;
        adc_sclk     = 1'b0;
        data_valid   = 1'b0;
        busy         = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = c_ST_CS_SETUP;
            end
            c_ST_CS_SETUP: begin
                adc_cs_n = 1'b0;
                if (w_phase_done) w_next_state = c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                adc_cs_n = 1'b0;
                adc_sclk = w_gen_sclk;
                if (w_shift_done) w_next_state = c_ST_GAP;
            end
            c_ST_GAP: begin
                if (w_phase_done) w_next_state = w_more_frames ? c_ST_CS_SETUP : c_ST_DONE;
            end
            c_ST_DONE: begin
                data_valid   = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_half     <= '0;
            r_frame    <= '0;
            r_shift    <= '0;
            r_acc      <= '0;
            r_adc_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_half  <= '0;
                        r_frame <= '0;
                        r_acc   <= '0;
                    end
                end
                c_ST_CS_SETUP: begin
                    r_cnt <= w_phase_done ? '0 : r_cnt + 1'b1;
                end
                c_ST_SHIFT: begin
                    if (w_rise) r_shift <= {r_shift[FRAME_BITS-2:0], adc_miso};
                    if (w_tick) r_half  <= r_half + 1'b1;
                    // The last half-period is the falling one, so r_shift is complete here.
                    if (w_shift_done) r_acc <= r_acc + c_ACC_W'(r_shift);
                end
                c_ST_GAP: begin
                    r_cnt <= w_phase_done ? '0 : r_cnt + 1'b1;
                    if (w_phase_done) begin
                        if (w_more_frames) r_frame    <= r_frame + 1'b1;
                        else               r_adc_data <= FRAME_BITS'(r_acc >> AVG_LOG2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : adc_sample_acquirer
`default_nettype wire
